mlaccel_qpi_responder: RTL and testbench
========================================

# mlaccel_qpi_responder

Device-side QPI responder for the mlaccel accelerator: the far end of the host's QPI command link. It oversamples the host-driven qpi_csb/qpi_clk/qpi_io lines on the core clock, deframes nibbles into a byte stream for the command decoder, and after the turnaround serializes response bytes back onto the shared IO lines. It sits between the top-level IO cells and the command/memory logic inside mlaccel_top.

## Interface
- SYNC_STAGES, 2, synchronizer flops on qpi_csb, qpi_clk, qpi_io_di (min 2)
- clock  in  1  core clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- qpi_csb  in  1  host chip select, active low
- qpi_clk  in  1  host QPI clock
- qpi_io_di  in  4  IO pad inputs, bit 3 = io3
- qpi_io_do  out  4  IO pad output data
- qpi_io_oe  out  1  IO pad output enable (1 = responder drives)
- xfer_active  out  1  synchronized csb asserted
- xfer_end  out  1  one-cycle pulse on synchronized csb deassertion
- rx_valid  out  1  one-cycle pulse: rx_data holds a received byte
- rx_data  out  8  received byte
- rx_first  out  1  qualifies rx_valid: first byte of this transfer (command)
- tx_req  in  1  level: core wants to respond; sampled at the turnaround rising edge
- tx_valid  in  1  tx_data holds the next response byte
- tx_data  in  8  response byte
- tx_ready  out  1  one-cycle pulse: tx_data consumed this cycle
- tx_underflow  out  1  one-cycle pulse: byte slot started with tx_valid low

## Operation
- All pads pass through SYNC_STAGES flops; one further register gives previous values for edge detection. Pad value "before the edge" = previous-sample io.
- States: IDLE, RX_SKIP, RX_HI, RX_LO, TX_HI, TX_LO.
- IDLE: on synced csb falling -> RX_SKIP if synced clk = 1, else RX_HI. Clear rx_first flag to 1.
- RX_SKIP: first qpi_clk falling edge -> RX_HI, nothing captured.
- RX_HI: qpi_clk rising edge -> capture io (pre-edge) as bits 7:4, -> RX_LO. If tx_req = 1 at this rising edge and at least one byte received: instead set qpi_io_oe = 1, qpi_io_do = 0, -> TX_HI (dummy turnaround edge, capture discarded).
- RX_LO: qpi_clk falling edge -> capture bits 3:0, pulse rx_valid with full byte, rx_first = flag, flag cleared, -> RX_HI.
- TX_HI: qpi_clk falling edge -> if tx_valid: drive tx_data[7:4], latch tx_data[3:0], pulse tx_ready; else drive 4'h0, latch 4'h0, pulse tx_underflow. -> TX_LO.
- TX_LO: qpi_clk rising edge -> drive latched low nibble, -> TX_HI.
- Any state: synced csb rising -> IDLE, qpi_io_oe = 0 same cycle, partial nibble discarded, no rx_valid, pulse xfer_end.
- Nibble order on the wire: high nibble first, io0 = LSB of nibble.

## Timing
- Reset values: qpi_io_oe 0, qpi_io_do 0, rx_valid/tx_ready/tx_underflow/xfer_end 0, rx_data 0, rx_first 0, xfer_active 0, state IDLE.
- Pad edge to internal detection: SYNC_STAGES+1 cycles. Detection to rx_valid / qpi_io_do update: 1 cycle (registered outputs).
- Host requirement: each qpi_clk half-period >= SYNC_STAGES+4 core cycles; host samples response nibble at end of half-period.
- rx path has no backpressure; core accepts every rx_valid.
- tx_req must be set before the rising edge following the last header byte's rx_valid (>= SYNC_STAGES+3 cycles margin at minimum half-period).
- tx_ready and tx_underflow never assert in the same cycle; one per byte slot.
- Simultaneous csb rise and qpi_clk edge: csb wins, edge ignored.
- resetn asserted mid-transfer: all outputs to reset values immediately; after release, a transfer already in progress is ignored until csb deasserts.

## Structure
- Shared package mlaccel_pkg: state enum, QPI command byte constants (0x20 status read, 0x21 code write, 0x23 data read, 0x25 run), SYNC_STAGES default.
- One natural sub-module: mlaccel_sync (parameterized multi-bit flop synchronizer, async active-low reset), instantiated for csb, clk, io.

## Test plan
- Write: csb low, clk high, send 0x21 then word 0x00080001 (LSB byte first) -> rx_valid x5: 0x21 (rx_first=1), 0x01, 0x00, 0x08, 0x00 (rx_first=0); qpi_io_oe stays 0.
- Status read: send 0x20, tx_req=1, core supplies 0x5A, 0x00 -> after dummy rising edge oe=1; host samples 0x5A then 0x00; two tx_ready pulses; oe=0 within SYNC_STAGES+1 cycles of csb rise.
- Underflow: read with tx_valid held low -> host samples 0x00, one tx_underflow per byte slot, no tx_ready.
- Abort: csb raised after high nibble 0xA of a byte -> no rx_valid, xfer_end pulse, next transfer's first byte 0x23 has rx_first=1.
- No turnaround: tx_req=0 during 0x25 + hword 0x0000 -> three rx_valid, oe never asserts.
- Reset mid-read: resetn low during TX_LO -> oe=0 immediately; after release, remaining clocks of that transfer produce no rx_valid/tx_ready; following transfer decodes normally.

Source files
------------

// File: rtl/mlaccel_pkg.sv
// mlaccel_pkg: shared QPI responder states, command bytes and default synchronizer depth
package mlaccel_pkg;
  localparam int SYNC_STAGES_DEF = 2;
  localparam logic [7:0] CMD_STATUS_RD = 8'h20;
  localparam logic [7:0] CMD_CODE_WR = 8'h21;
  localparam logic [7:0] CMD_DATA_RD = 8'h23;
  localparam logic [7:0] CMD_RUN = 8'h25;
  typedef enum logic [2:0] {IDLE, RX_SKIP, RX_HI, RX_LO, TX_HI, TX_LO} state_e;
endpackage

// File: rtl/mlaccel_sync.sv
// mlaccel_sync: W-bit STAGES-deep flop synchronizer (clock, resetn async low, d in, q out), resets to 0
module mlaccel_sync #(
  parameter int W = 1,
  parameter int STAGES = 2
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] ff_q [STAGES];
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      for (int i = 0; i < STAGES; i++) ff_q[i] <= '0;
    end else begin
      ff_q[0] <= d;
      for (int i = 1; i < STAGES; i++) ff_q[i] <= ff_q[i-1];
    end
  assign q = ff_q[STAGES-1];
endmodule

// File: rtl/mlaccel_qpi_responder.sv
// mlaccel_qpi_responder: QPI device responder; pads (csb/clk/io) -> rx byte stream, tx bytes -> io after turnaround
module mlaccel_qpi_responder
  import mlaccel_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       qpi_csb,
  input  logic       qpi_clk,
  input  logic [3:0] qpi_io_di,
  output logic [3:0] qpi_io_do,
  output logic       qpi_io_oe,
  output logic       xfer_active,
  output logic       xfer_end,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_first,
  input  logic       tx_req,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_underflow
);
  logic       csb_s, clk_s, csb_p_q, clk_p_q;
  logic [3:0] io_s, io_p_q;
  state_e     state_q, state_d;
  logic [3:0] do_q, do_d, hi_q, hi_d, lo_q, lo_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       oe_q, oe_d, rxv_q, rxv_d, rxf_q, rxf_d, flag_q, flag_d, got_q, got_d;
  logic       rdy_q, rdy_d, und_q, und_d, end_q, end_d, act_q;
  logic       csb_rise, csb_fall, clk_rise, clk_fall;
  mlaccel_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync_csb (.clock(clock), .resetn(resetn), .d(qpi_csb), .q(csb_s));
  mlaccel_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync_clk (.clock(clock), .resetn(resetn), .d(qpi_clk), .q(clk_s));
  mlaccel_sync #(.W(4), .STAGES(SYNC_STAGES)) u_sync_io (.clock(clock), .resetn(resetn), .d(qpi_io_di), .q(io_s));
  assign csb_rise = csb_s & ~csb_p_q;
  assign csb_fall = ~csb_s & csb_p_q;
  assign clk_rise = clk_s & ~clk_p_q;
  assign clk_fall = ~clk_s & clk_p_q;
  always_comb begin
    state_d = state_q;
    oe_d = oe_q;
    do_d = do_q;
    hi_d = hi_q;
    lo_d = lo_q;
    rx_data_d = rx_data_q;
    rxf_d = rxf_q;
    flag_d = flag_q;
    got_d = got_q;
    rxv_d = 1'b0;
    rdy_d = 1'b0;
    und_d = 1'b0;
    end_d = 1'b0;
    if (csb_rise && state_q != IDLE) begin
      state_d = IDLE;
      oe_d = 1'b0;
      do_d = 4'h0;
      end_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (csb_fall) begin
          state_d = clk_s ? RX_SKIP : RX_HI;
          flag_d = 1'b1;
          got_d = 1'b0;
        end
        RX_SKIP: if (clk_fall) state_d = RX_HI;
        RX_HI: if (clk_rise) begin
          if (tx_req && got_q) begin
            oe_d = 1'b1;
            do_d = 4'h0;
            state_d = TX_HI;
          end else begin
            hi_d = io_p_q;
            state_d = RX_LO;
          end
        end
        RX_LO: if (clk_fall) begin
          rxv_d = 1'b1;
          rx_data_d = {hi_q, io_p_q};
          rxf_d = flag_q;
          flag_d = 1'b0;
          got_d = 1'b1;
          state_d = RX_HI;
        end
        TX_HI: if (clk_fall) begin
          do_d = tx_valid ? tx_data[7:4] : 4'h0;
          lo_d = tx_valid ? tx_data[3:0] : 4'h0;
          rdy_d = tx_valid;
          und_d = ~tx_valid;
          state_d = TX_LO;
        end
        TX_LO: if (clk_rise) begin
          do_d = lo_q;
          state_d = TX_HI;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      csb_p_q <= 1'b0;
      clk_p_q <= 1'b0;
      io_p_q <= 4'h0;
      state_q <= IDLE;
      oe_q <= 1'b0;
      do_q <= 4'h0;
      hi_q <= 4'h0;
      lo_q <= 4'h0;
      rx_data_q <= 8'h0;
      rxf_q <= 1'b0;
      flag_q <= 1'b0;
      got_q <= 1'b0;
      rxv_q <= 1'b0;
      rdy_q <= 1'b0;
      und_q <= 1'b0;
      end_q <= 1'b0;
      act_q <= 1'b0;
    end else begin
      csb_p_q <= csb_s;
      clk_p_q <= clk_s;
      io_p_q <= io_s;
      state_q <= state_d;
      oe_q <= oe_d;
      do_q <= do_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      rx_data_q <= rx_data_d;
      rxf_q <= rxf_d;
      flag_q <= flag_d;
      got_q <= got_d;
      rxv_q <= rxv_d;
      rdy_q <= rdy_d;
      und_q <= und_d;
      end_q <= end_d;
      act_q <= state_d != IDLE;
    end
  assign qpi_io_oe = oe_q;
  assign qpi_io_do = do_q;
  assign xfer_active = act_q;
  assign xfer_end = end_q;
  assign rx_valid = rxv_q;
  assign rx_data = rx_data_q;
  assign rx_first = rxf_q;
  assign tx_ready = rdy_q;
  assign tx_underflow = und_q;
endmodule

// File: tb/tb_mlaccel_qpi_responder.sv
// tb_mlaccel_qpi_responder: directed host-side stimulus with immediate-assertion checks
module tb_mlaccel_qpi_responder;
  import mlaccel_pkg::*;
  localparam int H = 8;
  logic       clock = 1'b0, resetn = 1'b0, qpi_csb = 1'b1, qpi_clk = 1'b0;
  logic [3:0] qpi_io_di = 4'h0, qpi_io_do;
  logic       qpi_io_oe, xfer_active, xfer_end, rx_valid, rx_first, tx_ready, tx_underflow;
  logic [7:0] rx_data, tx_data;
  logic       tx_req = 1'b0, tx_valid = 1'b0, mon_clr = 1'b0, oe_seen;
  logic [7:0] txq [4];
  logic [7:0] rx_log [8];
  logic [7:0] rx_flog;
  logic [7:0] hs [2];
  logic [1:0] tx_idx;
  int         rx_n, rdy_n, und_n, end_n, n_cmp = 0, n_err = 0;
  mlaccel_qpi_responder #(.SYNC_STAGES(2)) dut (
    .clock(clock), .resetn(resetn), .qpi_csb(qpi_csb), .qpi_clk(qpi_clk),
    .qpi_io_di(qpi_io_di), .qpi_io_do(qpi_io_do), .qpi_io_oe(qpi_io_oe),
    .xfer_active(xfer_active), .xfer_end(xfer_end), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_first(rx_first), .tx_req(tx_req), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .tx_underflow(tx_underflow)
  );
  always #5 clock = ~clock;
  assign tx_data = txq[tx_idx];
  always @(negedge clock)
    if (mon_clr) begin
      rx_n <= 0; rdy_n <= 0; und_n <= 0; end_n <= 0; oe_seen <= 1'b0; tx_idx <= 2'd0; rx_flog <= 8'h0;
    end else begin
      if (rx_valid) begin
        rx_log[rx_n[2:0]] <= rx_data;
        rx_flog[rx_n[2:0]] <= rx_first;
        rx_n <= rx_n + 1;
      end
      if (tx_ready) begin
        rdy_n <= rdy_n + 1;
        tx_idx <= tx_idx + 2'd1;
      end
      if (tx_underflow) und_n <= und_n + 1;
      if (xfer_end) end_n <= end_n + 1;
      if (qpi_io_oe) oe_seen <= 1'b1;
    end
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clr();
    mon_clr = 1'b1;
    cyc(1);
    mon_clr = 1'b0;
  endtask
  task automatic start(input logic clk_hi);
    qpi_clk = clk_hi;
    cyc(2);
    qpi_csb = 1'b0;
    cyc(H);
    if (clk_hi) begin
      qpi_clk = 1'b0;
      cyc(H/2);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    qpi_io_di = b[7:4];
    cyc(H/2);
    qpi_clk = 1'b1;
    cyc(H/2);
    qpi_io_di = b[3:0];
    cyc(H/2);
    qpi_clk = 1'b0;
    cyc(H/2);
  endtask
  task automatic turnaround();
    cyc(H/2);
    qpi_clk = 1'b1;
    cyc(H);
  endtask
  task automatic rd2();
    for (int k = 0; k < 2; k++) begin
      qpi_clk = 1'b0;
      cyc(H);
      hs[k][7:4] = qpi_io_do;
      qpi_clk = 1'b1;
      cyc(H);
      hs[k][3:0] = qpi_io_do;
    end
  endtask
  task automatic stop();
    qpi_csb = 1'b1;
    qpi_io_di = 4'h0;
    cyc(H);
  endtask
  initial begin
    txq[0] = 8'h5A; txq[1] = 8'h00; txq[2] = 8'hEE; txq[3] = 8'hEE;
    cyc(1);
    clr();
    chk("rst_oe", {31'b0, qpi_io_oe}, 0);
    chk("rst_do", {28'b0, qpi_io_do}, 0);
    chk("rst_rxv", {31'b0, rx_valid}, 0);
    chk("rst_rxd", {24'b0, rx_data}, 0);
    chk("rst_rxf", {31'b0, rx_first}, 0);
    chk("rst_act", {31'b0, xfer_active}, 0);
    chk("rst_pulses", {29'b0, tx_ready, tx_underflow, xfer_end}, 0);
    cyc(3);
    resetn = 1'b1;
    cyc(4);
    // write: 0x21 + 0x00080001 LSB first
    clr();
    start(1'b1);
    chk("wr_active", {31'b0, xfer_active}, 1);
    send_byte(CMD_CODE_WR); send_byte(8'h01); send_byte(8'h00); send_byte(8'h08); send_byte(8'h00);
    stop();
    chk("wr_count", rx_n, 5);
    chk("wr_bytes", {rx_log[0], rx_log[1], rx_log[2], rx_log[3]}, 32'h21010008);
    chk("wr_byte4", {24'b0, rx_log[4]}, 32'h00);
    chk("wr_first", {24'b0, rx_flog}, 32'h01);
    chk("wr_oe", {31'b0, oe_seen}, 0);
    chk("wr_end", end_n, 1);
    chk("wr_inactive", {31'b0, xfer_active}, 0);
    // status read
    clr();
    tx_req = 1'b1; tx_valid = 1'b1;
    start(1'b0);
    send_byte(CMD_STATUS_RD);
    turnaround();
    chk("rd_oe_on", {31'b0, qpi_io_oe}, 1);
    chk("rd_dummy_do", {28'b0, qpi_io_do}, 0);
    rd2();
    qpi_csb = 1'b1;
    cyc(4);
    chk("rd_oe_off", {31'b0, qpi_io_oe}, 0);
    cyc(H);
    chk("rd_data", {16'b0, hs[0], hs[1]}, 32'h5A00);
    chk("rd_ready", rdy_n, 2);
    chk("rd_und", und_n, 0);
    chk("rd_rx", rx_n, 1);
    // underflow
    clr();
    tx_valid = 1'b0;
    start(1'b1);
    send_byte(CMD_DATA_RD);
    turnaround();
    rd2();
    stop();
    chk("uf_data", {16'b0, hs[0], hs[1]}, 32'h0000);
    chk("uf_und", und_n, 2);
    chk("uf_ready", rdy_n, 0);
    tx_req = 1'b0;
    // abort after high nibble
    clr();
    start(1'b0);
    qpi_io_di = 4'hA;
    cyc(H/2);
    qpi_clk = 1'b1;
    cyc(H/2);
    stop();
    chk("ab_rx", rx_n, 0);
    chk("ab_end", end_n, 1);
    clr();
    start(1'b1);
    send_byte(CMD_DATA_RD);
    stop();
    chk("ab_next_n", rx_n, 1);
    chk("ab_next", {23'b0, rx_flog[0], rx_log[0]}, 32'h123);
    // no turnaround
    clr();
    start(1'b0);
    send_byte(CMD_RUN); send_byte(8'h00); send_byte(8'h00);
    stop();
    chk("nt_count", rx_n, 3);
    chk("nt_bytes", {8'b0, rx_log[0], rx_log[1], rx_log[2]}, 32'h250000);
    chk("nt_oe", {31'b0, oe_seen}, 0);
    // reset during TX_LO
    clr();
    tx_req = 1'b1; tx_valid = 1'b1;
    start(1'b1);
    send_byte(CMD_STATUS_RD);
    turnaround();
    qpi_clk = 1'b0;
    cyc(H);
    chk("rs_oe_pre", {31'b0, qpi_io_oe}, 1);
    chk("rs_do_pre", {28'b0, qpi_io_do}, 4'h5);
    resetn = 1'b0;
    #1;
    chk("rs_oe_async", {31'b0, qpi_io_oe}, 0);
    chk("rs_do_async", {28'b0, qpi_io_do}, 0);
    cyc(2);
    resetn = 1'b1;
    clr();
    send_byte(8'h77); send_byte(8'h77);
    stop();
    chk("rs_ign_rx", rx_n, 0);
    chk("rs_ign_rdy", rdy_n, 0);
    chk("rs_ign_oe", {31'b0, oe_seen}, 0);
    tx_req = 1'b0;
    clr();
    start(1'b1);
    send_byte(CMD_CODE_WR); send_byte(8'h55);
    stop();
    chk("rs_after_n", rx_n, 2);
    chk("rs_after", {22'b0, rx_flog[1:0], rx_log[0], rx_log[1]}, 32'h12155);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
